// File: rtl/csa_sbox_pkg.sv
// csa_sbox_pkg: default CSA S-box tables and lane default lookup
package csa_sbox_pkg;

    localparam int SBOX_N = 7;
    localparam int SBOX_DEPTH = 32;

    localparam int SBOX [SBOX_N][SBOX_DEPTH] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

    // entry a of the returned table sits in bits [2*a +: 2]; lane i uses S-box (i mod 7)+1
    function automatic logic [2*SBOX_DEPTH-1:0] sbox_default(input int lane);
        logic [2*SBOX_DEPTH-1:0] t;
        for (int a = 0; a < SBOX_DEPTH; a++)
            t[2*a +: 2] = 2'(SBOX[lane % SBOX_N][a]);
        return t;
    endfunction

endpackage

// File: rtl/csa_sbox_table.sv
// csa_sbox_table: one lane's writable lookup table with restore and async read
module csa_sbox_table
    import csa_sbox_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 2,
    parameter int LANE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restore,
    input  logic             we,
    input  logic [IN_W-1:0]  waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic [IN_W-1:0]  raddr,
    output logic [OUT_W-1:0] rdata
);

    localparam int DEPTH = 2**IN_W;

    // only the 32x2 geometry has CSA defaults; any other shape starts zeroed
    function automatic logic [DEPTH-1:0][OUT_W-1:0] init_tbl();
        logic [DEPTH-1:0][OUT_W-1:0] t;
        logic [2*SBOX_DEPTH-1:0] s;
        t = '0;
        s = sbox_default(LANE);
        if (IN_W == 5 && OUT_W == 2)
            for (int a = 0; a < SBOX_DEPTH; a++)
                t[a] = OUT_W'(s[2*a +: 2]);
        return t;
    endfunction

    localparam logic [DEPTH-1:0][OUT_W-1:0] DEF = init_tbl();

    logic [DEPTH-1:0][OUT_W-1:0] mem;

    // reset and restore reload defaults and win over a same-edge write
    always_ff @(posedge clk) begin
        if (rst || restore)
            mem <= DEF;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/csa_sbox_engine.sv
// csa_sbox_engine: multi-lane CSA S-box lookup with a two-stage valid/ready pipeline
module csa_sbox_engine
    import csa_sbox_pkg::*;
#(
    parameter int LANES = 7,
    parameter int IN_W  = 5,
    parameter int OUT_W = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [LANES*IN_W-1:0]                    in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [LANES*OUT_W-1:0]                   out_data,
    input  logic                                     cfg_we,
    input  logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] cfg_lane,
    input  logic [IN_W-1:0]                          cfg_addr,
    input  logic [OUT_W-1:0]                         cfg_wdata,
    input  logic                                     cfg_restore
);

    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;

    logic                   s1_v;
    logic [LANES*IN_W-1:0]  s1_addr;
    logic [LANES*OUT_W-1:0] rd;
    logic                   s2_adv;
    logic                   s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;

    // lane select compare drops writes to lanes that do not exist
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        csa_sbox_table #(.IN_W(IN_W), .OUT_W(OUT_W), .LANE(i)) u_tbl (
            .clk     (clk),
            .rst     (rst),
            .restore (cfg_restore),
            .we      (cfg_we && cfg_lane == LW'(i)),
            .waddr   (cfg_addr),
            .wdata   (cfg_wdata),
            .raddr   (s1_addr[i*IN_W +: IN_W]),
            .rdata   (rd[i*OUT_W +: OUT_W])
        );
    end

    // S1 captures addresses, S2 captures the table read that sees pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v)
                    out_data <= rd;
            end
            if (s1_adv) begin
                s1_v <= in_valid;
                if (in_valid)
                    s1_addr <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_csa_sbox_engine.sv
// tb_csa_sbox_engine: directed and random checks against a queue-based reference model
module tb_csa_sbox_engine;

    localparam int L  = 7;
    localparam int IW = 5;
    localparam int OW = 2;
    localparam int LW = 3;
    localparam int DW = L*IW;
    localparam int QW = L*OW;

    localparam int SB [7][32] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, cfg_we, cfg_restore;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data;
    logic [QW-1:0] out_data;
    logic [LW-1:0] cfg_lane;
    logic [IW-1:0] cfg_addr;
    logic [OW-1:0] cfg_wdata;

    always #5 clk = ~clk;

    csa_sbox_engine #(.LANES(L), .IN_W(IW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_restore(cfg_restore)
    );

    int            tbl [L][32];
    logic [DW-1:0] pend [$];
    logic [QW-1:0] outq [$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            fired = 0;
    bit            exp_ov, exp_ir, accepted;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void load_defaults();
        for (int i = 0; i < L; i++)
            for (int a = 0; a < 32; a++)
                tbl[i][a] = SB[i % 7][a];
    endfunction

    function automatic logic [QW-1:0] lookup(input logic [DW-1:0] ad);
        logic [QW-1:0] r;
        for (int i = 0; i < L; i++)
            r[i*OW +: OW] = OW'(tbl[i][ad[i*IW +: IW]]);
        return r;
    endfunction

    function automatic logic [DW-1:0] req4(input int a);
        logic [DW-1:0] d;
        d = DW'({$urandom(), $urandom()});
        d[4*IW +: IW] = IW'(a);
        return d;
    endfunction

    function automatic logic [DW-1:0] all_lanes(input int a);
        logic [DW-1:0] d;
        for (int i = 0; i < L; i++)
            d[i*IW +: IW] = IW'(a);
        return d;
    endfunction

    // called at a falling edge with inputs driven; checks, advances model, moves to next falling edge
    task automatic cycle();
        bit s2_move;
        #1;
        exp_ov = outq.size() != 0;
        exp_ir = pend.size() == 0 || !exp_ov || out_ready;
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        if (exp_ov)
            chk("out_data", out_data, outq[0]);
        accepted = 1'b0;
        if (rst) begin
            pend.delete();
            outq.delete();
            load_defaults();
        end else begin
            s2_move = !exp_ov || out_ready;
            if (exp_ov && out_ready) begin
                void'(outq.pop_front());
                fired++;
            end
            if (s2_move && pend.size() != 0)
                outq.push_back(lookup(pend.pop_front()));
            if (in_valid && exp_ir) begin
                pend.push_back(in_data);
                accepted = 1'b1;
            end
            if (cfg_restore)
                load_defaults();
            else if (cfg_we && cfg_lane < L)
                tbl[cfg_lane][cfg_addr] = int'(cfg_wdata);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cfg_restore = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rq [4];
        int k, f0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_restore = 1'b0;
        in_data = '0; cfg_lane = '0; cfg_addr = '0; cfg_wdata = '0;
        load_defaults();
        @(posedge clk);
        @(negedge clk);
        cycle();
        idle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, '0);

        // back-to-back lookups on lane 4
        in_valid = 1'b1; in_data = req4(5'h00); cycle();
        in_data = req4(5'h04); cycle();
        chk("b2b_0x00", out_data[4*OW +: OW], 2'd2);
        in_data = req4(5'h1F); cycle();
        chk("b2b_0x04", out_data[4*OW +: OW], 2'd3);
        in_valid = 1'b0; cycle();
        chk("b2b_0x1F", out_data[4*OW +: OW], 2'd2);
        chk("b2b_valid", out_valid, 1'b1);
        cycle();

        // write on the same edge the read happens returns old data
        in_valid = 1'b1; in_data = req4(5'h04); cycle();
        in_valid = 1'b0; cfg_we = 1'b1; cfg_lane = 3'd4; cfg_addr = 5'h04; cfg_wdata = 2'd0; cycle();
        chk("rbw_old", out_data[4*OW +: OW], 2'd3);
        cfg_we = 1'b0; in_valid = 1'b1; in_data = req4(5'h04); cycle();
        in_valid = 1'b0; cycle();
        chk("rbw_new", out_data[4*OW +: OW], 2'd0);
        cycle();

        // backpressure: only two requests fit while the output is stalled
        for (int i = 0; i < 4; i++) rq[i] = req4(i + 8);
        out_ready = 1'b0; k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = k < 4; in_data = rq[k < 4 ? k : 3]; cycle();
            if (accepted) k++;
        end
        chk("bp_accepts", k, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1; f0 = fired;
        for (int c = 0; c < 20 && (k < 4 || outq.size() != 0 || pend.size() != 0); c++) begin
            in_valid = k < 4; in_data = rq[k < 4 ? k : 3]; cycle();
            if (accepted) k++;
        end
        in_valid = 1'b0; cycle();
        chk("bp_results", fired - f0, 4);

        // restore beats a simultaneous write; out-of-range lane write is dropped
        cfg_we = 1'b1; cfg_lane = 3'd0; cfg_addr = 5'h00; cfg_wdata = 2'd3; cycle();
        cfg_restore = 1'b1; cfg_lane = 3'd1; cfg_addr = 5'h01; cfg_wdata = 2'd3; cycle();
        cfg_restore = 1'b0; cfg_lane = 3'd7; cfg_addr = 5'h05; cfg_wdata = 2'd1; cycle();
        cfg_we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            in_valid = 1'b1; in_data = all_lanes(a); cycle();
        end
        in_valid = 1'b1; in_data = req4(5'h04); cycle();
        in_valid = 1'b0; cycle();
        chk("restore_l4", out_data[4*OW +: OW], 2'd3);
        cycle(); cycle();

        // reset with both stages full
        cfg_we = 1'b1; cfg_lane = 3'd4; cfg_addr = 5'h04; cfg_wdata = 2'd0; cycle();
        cfg_we = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = req4(1); cycle();
        in_data = req4(2); cycle();
        chk("full_in_ready", in_ready, 1'b0);
        rst = 1'b1; cfg_we = 1'b1; cfg_restore = 1'b1; cycle();
        idle(); out_ready = 1'b1;
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = req4(5'h04); cycle();
        in_valid = 1'b0; cycle();
        chk("rst2_default", out_data[4*OW +: OW], 2'd3);
        cycle(); cycle();

        // random traffic
        for (int c = 0; c < 10000; c++) begin
            rst         = $urandom_range(0, 499) == 0;
            in_valid    = $urandom_range(0, 2) != 0;
            in_data     = DW'({$urandom(), $urandom()});
            out_ready   = $urandom_range(0, 3) != 0;
            cfg_we      = $urandom_range(0, 3) == 0;
            cfg_restore = $urandom_range(0, 49) == 0;
            cfg_lane    = LW'($urandom_range(0, 7));
            cfg_addr    = IW'($urandom());
            cfg_wdata   = OW'($urandom());
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_sbox_engine.md
CSA_SBOX_ENGINE -- requirements
Module: csa_sbox_engine

Interface
REQ-001 Parameter LANES, default 7, number of parallel S-box lanes (1..16).
REQ-002 Parameter IN_W, default 5, lookup address width per lane; table depth 2**IN_W.
REQ-003 Parameter OUT_W, default 2, result width per lane.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  lookup request valid.
REQ-007 in_ready  output  1  engine can accept a request this cycle.
REQ-008 in_data  input  LANES*IN_W  lane i address in bits [i*IN_W +: IN_W].
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_data  output  LANES*OUT_W  lane i result in bits [i*OUT_W +: OUT_W].
REQ-012 cfg_we  input  1  table entry write strobe.
REQ-013 cfg_lane  input  $clog2(LANES) (min 1)  lane selected for write.
REQ-014 cfg_addr  input  IN_W  table entry address.
REQ-015 cfg_wdata  input  OUT_W  table entry data.
REQ-016 cfg_restore  input  1  reload all tables with default contents.

Function
REQ-017 Each lane SHALL hold a private writable table of 2**IN_W entries of OUT_W bits.
REQ-018 Request accepted on a rising edge where in_valid && in_ready.
REQ-019 Two-stage pipeline: S1 registers addresses, S2 registers table read; with out_ready held high, out_valid SHALL rise exactly 2 edges after acceptance; throughput one request per cycle.
REQ-020 S2 SHALL advance when S2 empty or out_ready; S1 SHALL advance when S1 empty or S2 advances; in_ready = S1 empty or S2 advances (combinational from out_ready, no combinational path from in_valid).
REQ-021 While out_valid && !out_ready, out_data SHALL remain stable; no request lost or duplicated; results in acceptance order.
REQ-022 Table read at the S1->S2 edge SHALL return contents before any write on that same edge (read-before-write); the write is visible to reads on later edges.
REQ-023 cfg_we SHALL write cfg_wdata to table[cfg_lane][cfg_addr] in one edge; cfg_lane >= LANES SHALL be ignored.
REQ-024 cfg_restore SHALL reload all lanes with defaults in one edge and take priority over a simultaneous cfg_we.
REQ-025 Configuration writes SHALL never stall the lookup path.
REQ-026 Default table for lane i SHALL be CSA S-box ((i mod 7)+1) per ETSI CSA; for IN_W/OUT_W other than 5/2, default contents SHALL be all zeros.
REQ-027 CSA S-box 5 default (addresses 0x00..0x1F): 2,0,0,1,3,2,3,2,0,1,3,3,1,0,2,1,2,3,2,0,0,3,1,1,1,0,3,2,3,1,0,2.

Reset
REQ-028 On rst: S1/S2 valid cleared, out_valid=0, out_data=0, in_ready=1 on the following cycle, all tables reloaded with defaults.
REQ-029 rst mid-operation SHALL discard in-flight requests; no result for them SHALL appear after reset.
REQ-030 rst SHALL take priority over cfg_we, cfg_restore and in_valid in the same cycle.

Structure
REQ-031 Package csa_sbox_pkg SHALL hold the seven default 32x2 S-box constant tables and a function returning the default table for a lane index.
REQ-032 One sub-module csa_sbox_table (one lane: register file, write port, restore, combinational read) SHALL be instantiated LANES times.

Verification
REQ-033 Reset, LANES=7, lane 4 (S-box 5) addresses 0x00,0x04,0x1F back-to-back, out_ready=1 -> lane 4 results 2,3,2 on three consecutive cycles starting 2 edges after the first accept.
REQ-034 Write lane 4 addr 0x04 = 0 on the same edge the lookup of 0x04 moves S1->S2 -> result 3; repeat lookup -> 0.
REQ-035 Hold out_ready=0 for 5 cycles while driving 4 requests -> in_ready falls after 2 accepts; on release all 4 results appear in order, none duplicated.
REQ-036 cfg_restore and cfg_we asserted together after modifying entries -> all tables equal defaults; cfg_lane=7 write -> no table changes.
REQ-037 Assert rst with both stages full -> next cycle out_valid=0, in_ready=1; modified entries back to default values.
REQ-038 Random lookup/config/backpressure traffic against a reference model -> zero mismatches over 10k cycles.
